// File: rtl/pixel_frame_collector_pkg.sv
// Shared constants, FSM state type and pixel-index helper for the frame collector
// and the downstream pooling stage.
package pixel_frame_collector_pkg;

    localparam int RESOLUTION    = 8;
    localparam int FRAME_WIDTH   = 4;
    localparam int FRAME_HEIGHT  = 4;
    localparam int PIXELS_NUMBER = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int COUNT_W       = $clog2(PIXELS_NUMBER);
    localparam int FRAME_BITS    = RESOLUTION * PIXELS_NUMBER;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    typedef logic [COUNT_W-1:0] count_t;

    // Raster position of pixel (r,c); the pooling stage uses the same mapping for its taps.
    function automatic int unsigned pixel_index(input int unsigned r, input int unsigned c);
        return r * FRAME_WIDTH + c;
    endfunction

endpackage

// File: rtl/pixel_frame_collector_if.sv
// Pixel stream in, assembled frame out; master drives the stream and consumes frames.
interface pixel_frame_collector_if;
    import pixel_frame_collector_pkg::*;

    logic [RESOLUTION-1:0] in_pixel;
    logic                  in_valid;
    logic                  in_sof;
    logic                  in_ready;
    logic [FRAME_BITS-1:0] pixels;
    logic                  frame_valid;
    logic                  frame_ready;
    logic                  sync_error;

    modport master (
        output in_pixel, in_valid, in_sof, frame_ready,
        input  in_ready, pixels, frame_valid, sync_error
    );

    modport slave (
        input  in_pixel, in_valid, in_sof, frame_ready,
        output in_ready, pixels, frame_valid, sync_error
    );

endinterface

// File: rtl/pixel_frame_collector_pixel_index_counter.sv
// Raster write-index counter: load 0, load 1, or increment; flags the last slot.
module pixel_index_counter
    import pixel_frame_collector_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load0,
    input  logic   load1,
    input  logic   inc,
    output count_t count,
    output logic   terminal
);

    count_t count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load0) begin
            count_d = '0;
        end else if (load1) begin
            count_d = COUNT_W'(1);
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign terminal = (count_q == COUNT_W'(PIXELS_NUMBER - 1));

endmodule

// File: rtl/pixel_frame_collector.sv
// Collects a raster-ordered pixel stream into a flat frame and holds it until the
// downstream pooling stage acknowledges it.
module pixel_frame_collector
    import pixel_frame_collector_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    pixel_frame_collector_if.slave   bus
);

    state_e                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  sync_error_q, sync_error_d;
    logic [RESOLUTION-1:0] pix_q [PIXELS_NUMBER];
    logic [RESOLUTION-1:0] pix_d [PIXELS_NUMBER];

    count_t count;
    count_t wr_idx;
    logic   terminal;
    logic   accept;
    logic   load0, load1, inc;

    pixel_index_counter u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load0    (load0),
        .load1    (load1),
        .inc      (inc),
        .count    (count),
        .terminal (terminal)
    );

    always_comb begin
        state_d      = state_q;
        sync_error_d = 1'b0;
        load0        = 1'b0;
        load1        = 1'b0;
        inc          = 1'b0;
        accept       = 1'b0;
        wr_idx       = count;
        pix_d        = pix_q;
        unique case (state_q)
            FILL: begin
                // in_ready_q is low for the first cycle out of reset, gating accepts.
                accept = bus.in_valid & in_ready_q;
                if (accept) begin
                    if (bus.in_sof) begin
                        wr_idx       = '0;
                        load1        = 1'b1;
                        sync_error_d = (count != '0);
                    end else if (terminal) begin
                        load0   = 1'b1;
                        state_d = HOLD;
                    end else begin
                        inc = 1'b1;
                    end
                    pix_d[wr_idx] = bus.in_pixel;
                end
            end
            HOLD: begin
                if (bus.frame_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        in_ready_d    = (state_d == FILL);
        frame_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FILL;
            in_ready_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            sync_error_q  <= 1'b0;
            for (int i = 0; i < PIXELS_NUMBER; i++) begin
                pix_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            frame_valid_q <= frame_valid_d;
            sync_error_q  <= sync_error_d;
            pix_q         <= pix_d;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < FRAME_HEIGHT; gi++) begin : g_row
            for (gj = 0; gj < FRAME_WIDTH; gj++) begin : g_col
                localparam int IDX = pixel_index(gi, gj);
                assign bus.pixels[IDX*RESOLUTION +: RESOLUTION] = pix_q[IDX];
            end
        end
    endgenerate

    assign bus.in_ready    = in_ready_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.sync_error  = sync_error_q;

endmodule
